// File: rtl/apu_sequencer.sv
// Frame-timed APU register sequencer: plays 16-bit command words from a program ROM
// into a 16-byte register image shared with a higher-priority host write port.

module apu_seq_reg_byte (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic [7:0] q
);
  always_ff @(posedge clk) begin
    if (reset)      q <= '0;
    else if (wr_en) q <= wr_data;
  end
endmodule

module apu_sequencer #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable_240hz,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  host_wr,
  input  logic [3:0]            host_addr,
  input  logic [7:0]            host_data,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [15:0]           rom_data,
  output logic [127:0]          reg_data,
  output logic [3:0]            reg_event,
  output logic                  busy
);
  localparam int NUM_REGS = 16;

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, WAIT} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] pc, pc_nxt;
  logic [8:0]            count, count_nxt;
  logic                  seq_wr;
  logic [3:0]            seq_addr;
  logic [7:0]            seq_data;
  logic [3:0]            event_nxt;

  logic [NUM_REGS-1:0]      byte_we;
  logic [7:0]               byte_wd;
  logic [NUM_REGS-1:0][7:0] byte_q;

  assign seq_addr = rom_data[11:8];
  assign seq_data = rom_data[7:0];

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    count_nxt = count;
    seq_wr    = 1'b0;
    case (state)
      IDLE: if (start) begin
        pc_nxt    = '0;
        state_nxt = FETCH;
      end
      FETCH: state_nxt = EXEC;
      EXEC: case (rom_data[15:14])
        2'b00: if (!host_wr) begin
          // a host write in this cycle owns the register port; retry next cycle
          seq_wr    = 1'b1;
          pc_nxt    = pc + ADDR_WIDTH'(1);
          state_nxt = FETCH;
        end
        2'b01: begin
          count_nxt = (rom_data[7:0] == 8'd0) ? 9'd256 : {1'b0, rom_data[7:0]};
          pc_nxt    = pc + ADDR_WIDTH'(1);
          state_nxt = WAIT;
        end
        2'b10: begin
          pc_nxt    = rom_data[ADDR_WIDTH-1:0];
          state_nxt = FETCH;
        end
        default: state_nxt = IDLE;
      endcase
      WAIT: if (enable_240hz) begin
        count_nxt = count - 9'd1;
        if (count == 9'd1) state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
    if (stop) begin
      state_nxt = IDLE;
      pc_nxt    = pc;
      count_nxt = count;
      seq_wr    = 1'b0;
    end
  end

  always_comb begin
    event_nxt = '0;
    if (host_wr) event_nxt[host_addr[3:2]] = 1'b1;
    if (seq_wr)  event_nxt[seq_addr[3:2]]  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= '0;
      count     <= '0;
      reg_event <= '0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      count     <= count_nxt;
      reg_event <= event_nxt;
    end
  end

  // host and sequencer never write together: the sequencer stalls on host_wr
  assign byte_wd = host_wr ? host_data : seq_data;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    assign byte_we[i] = (host_wr && host_addr == 4'(i)) || (seq_wr && seq_addr == 4'(i));
    apu_seq_reg_byte u_byte (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (byte_we[i]),
      .wr_data (byte_wd),
      .q       (byte_q[i])
    );
  end

  assign reg_data = byte_q;
  assign rom_addr = pc;
  assign busy     = (state != IDLE);
endmodule

// File: tb/tb_apu_sequencer.sv
// Directed bench for apu_sequencer: ROM model, event scoreboard and direct output checks.

module tb_apu_sequencer;
  logic         clk = 1'b0;
  logic         reset, enable_240hz, start, stop, host_wr;
  logic [3:0]   host_addr;
  logic [7:0]   host_data;
  logic [7:0]   rom_addr;
  logic [15:0]  rom_data;
  logic [127:0] reg_data;
  logic [3:0]   reg_event;
  logic         busy;

  logic [15:0] rom [256];

  typedef struct {
    string      tag;
    logic [3:0] ev;
    int         idx;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  apu_sequencer #(.ADDR_WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable_240hz (enable_240hz),
    .start        (start),
    .stop         (stop),
    .host_wr      (host_wr),
    .host_addr    (host_addr),
    .host_data    (host_data),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .reg_data     (reg_data),
    .reg_event    (reg_event),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  // scoreboard: every register strobe must match the oldest pending expectation
  always @(negedge clk) begin
    if (reg_event != 4'b0) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_event: observed ev=%b expected none", reg_event);
      end
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        n_cmp++;
        assert (reg_event === e.ev) else begin
          n_err++;
          $error("FAIL %s_ev: observed %b expected %b", e.tag, reg_event, e.ev);
        end
        n_cmp++;
        assert (reg_data[8*e.idx +: 8] === e.data) else begin
          n_err++;
          $error("FAIL %s_data: observed %h expected %h", e.tag, reg_data[8*e.idx +: 8], e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [3:0] ev, input int idx, input logic [7:0] data);
    exp_t e;
    e.tag = tag; e.ev = ev; e.idx = idx; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'hC000;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable_240hz = 1'b0; start = 1'b0; stop = 1'b0;
    host_wr = 1'b0; host_addr = 4'h0; host_data = 8'h00;
    clear_rom();
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_reg_data", reg_data, 128'h0);
    chk("rst_reg_event", {124'h0, reg_event}, 128'h0);
    chk("rst_rom_addr", {120'h0, rom_addr}, 128'h0);
    chk("rst_busy", {127'h0, busy}, 128'h0);

    // WRITE 3,A5 then STOP: strobe lands on the 3rd edge after start
    rom[0] = 16'h03A5; rom[1] = 16'hC000;
    push("wr3", 4'b0001, 3, 8'hA5);
    pulse_start();
    chk("busy_rise", {127'h0, busy}, 128'h1);
    step();
    chk("wr3_not_yet", {124'h0, reg_event}, 128'h0);
    step();
    chk("wr3_ev", {124'h0, reg_event}, 128'h1);
    chk("wr3_byte", {120'h0, reg_data[31:24]}, 128'hA5);
    step();
    chk("wr3_ev_one_cycle", {124'h0, reg_event}, 128'h0);
    chk("busy_before_stop", {127'h0, busy}, 128'h1);
    step();
    chk("busy_fall", {127'h0, busy}, 128'h0);

    // WAIT 3 then WRITE C,1F
    rom[0] = 16'h4003; rom[1] = 16'h0C1F; rom[2] = 16'hC000;
    pulse_start(); step(); step();
    chk("wait3_rom_addr", {120'h0, rom_addr}, 128'h1);
    enable_240hz = 1'b1; step(); enable_240hz = 1'b0; step(); step();
    enable_240hz = 1'b1; step(); enable_240hz = 1'b0; step();
    chk("wait3_busy", {127'h0, busy}, 128'h1);
    push("wrC", 4'b1000, 12, 8'h1F);
    enable_240hz = 1'b1; step(); enable_240hz = 1'b0;
    chk("wait3_no_ev", {124'h0, reg_event}, 128'h0);
    step(); step();
    chk("wrC_ev", {124'h0, reg_event}, 128'h8);
    chk("wrC_byte", {120'h0, reg_data[103:96]}, 128'h1F);
    step(); step();
    chk("wait3_done_busy", {127'h0, busy}, 128'h0);

    // WAIT 0 means 256 ticks
    rom[0] = 16'h4000; rom[1] = 16'h0401; rom[2] = 16'hC000;
    pulse_start(); step(); step();
    enable_240hz = 1'b1;
    repeat (255) step();
    chk("wait256_busy", {127'h0, busy}, 128'h1);
    chk("wait256_rom_addr", {120'h0, rom_addr}, 128'h1);
    push("wr4", 4'b0010, 4, 8'h01);
    step();
    enable_240hz = 1'b0;
    step(); step();
    chk("wr4_ev", {124'h0, reg_event}, 128'h2);
    step(); step();
    chk("wait256_done_busy", {127'h0, busy}, 128'h0);

    // host/sequencer collision on byte 5
    rom[0] = 16'h0522; rom[1] = 16'hC000;
    pulse_start(); step();
    host_wr = 1'b1; host_addr = 4'h5; host_data = 8'h11;
    push("col_host", 4'b0010, 5, 8'h11);
    push("col_seq", 4'b0010, 5, 8'h22);
    step();
    host_wr = 1'b0;
    chk("col_host_byte", {120'h0, reg_data[47:40]}, 128'h11);
    step();
    chk("col_seq_byte", {120'h0, reg_data[47:40]}, 128'h22);
    chk("col_seq_ev", {124'h0, reg_event}, 128'h2);
    step(); step();
    chk("col_done_busy", {127'h0, busy}, 128'h0);

    // JUMP to 0xFF, WRITE there, pc wraps to a STOP at 0
    rom[0] = 16'h80FF; rom[255] = 16'h0E77;
    pulse_start(); step();
    rom[0] = 16'hC000;
    step();
    chk("jump_rom_addr", {120'h0, rom_addr}, 128'hFF);
    push("wrE", 4'b1000, 14, 8'h77);
    step(); step();
    chk("wrap_rom_addr", {120'h0, rom_addr}, 128'h0);
    chk("wrE_byte", {120'h0, reg_data[119:112]}, 128'h77);
    step(); step();
    chk("wrap_done_busy", {127'h0, busy}, 128'h0);

    // stop mid-WAIT, then start+stop together in IDLE
    rom[0] = 16'h4005; rom[1] = 16'h0101; rom[2] = 16'hC000;
    pulse_start(); step(); step();
    enable_240hz = 1'b1; step(); enable_240hz = 1'b0;
    stop = 1'b1; step(); stop = 1'b0;
    chk("stop_wait_busy", {127'h0, busy}, 128'h0);
    enable_240hz = 1'b1; repeat (6) step(); enable_240hz = 1'b0;
    chk("stop_wait_rom_addr", {120'h0, rom_addr}, 128'h1);
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    chk("start_stop_busy", {127'h0, busy}, 128'h0);
    chk("start_stop_rom_addr", {120'h0, rom_addr}, 128'h1);

    // start while busy is ignored
    rom[0] = 16'h4002;
    pulse_start(); step(); step();
    pulse_start();
    chk("start_busy_rom_addr", {120'h0, rom_addr}, 128'h1);
    chk("start_busy_busy", {127'h0, busy}, 128'h1);
    stop = 1'b1; step(); stop = 1'b0;
    chk("stop_busy", {127'h0, busy}, 128'h0);

    // host write while idle
    host_wr = 1'b1; host_addr = 4'hF; host_data = 8'h5A;
    push("host_idle", 4'b1000, 15, 8'h5A);
    step();
    host_wr = 1'b0;
    chk("host_idle_byte", {120'h0, reg_data[127:120]}, 128'h5A);

    // reset during EXEC of a WRITE
    rom[0] = 16'h0101; rom[1] = 16'hC000;
    pulse_start(); step();
    reset = 1'b1; step(); reset = 1'b0;
    chk("rst_exec_reg_data", reg_data, 128'h0);
    chk("rst_exec_busy", {127'h0, busy}, 128'h0);
    chk("rst_exec_rom_addr", {120'h0, rom_addr}, 128'h0);
    step();
    chk("rst_exec_no_ev", {124'h0, reg_event}, 128'h0);

    step(); step();
    chk("scoreboard_drained", 128'(exp_q.size()), 128'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
